// File: rtl/result_streamer.sv
// Snapshots the WIDTH x WIDTH result matrix on the rising edge of done and streams it row-major.
// Define RESULT_CHECKSUM_EN to append a wrapping 32-bit checksum beat to each frame.
module result_streamer #(
    parameter int unsigned WIDTH_BIT = 2,
    parameter int unsigned WIDTH     = 2**WIDTH_BIT
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                done,
    input  logic [0:WIDTH-1][0:WIDTH-1][31:0]   result,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [31:0]                         out_data,
    output logic [WIDTH_BIT-1:0]                out_row,
    output logic [WIDTH_BIT-1:0]                out_col,
    output logic                                out_last,
    output logic                                out_is_chk,
    output logic                                busy,
    output logic                                overrun
);

    localparam logic [WIDTH_BIT-1:0] LastIdx = WIDTH_BIT'(WIDTH - 1);

`ifdef RESULT_CHECKSUM_EN
    typedef enum logic [1:0] {StIdle, StStream, StChk} state_t;
`else
    typedef enum logic [1:0] {StIdle, StStream} state_t;
`endif

    state_t                              r_state;
    logic                                r_done_q;
    logic [0:WIDTH-1][0:WIDTH-1][31:0]   r_snap;
    logic [WIDTH_BIT-1:0]                r_row;
    logic [WIDTH_BIT-1:0]                r_col;
    logic [31:0]                         r_data;
    logic                                r_valid;
    logic                                r_last;
    logic                                r_busy;
    logic                                r_overrun;
`ifdef RESULT_CHECKSUM_EN
    logic [31:0]                         r_sum;
    logic                                r_is_chk;
`endif

    logic                                w_start;
    logic                                w_hs;
    logic                                w_final;
    logic [WIDTH_BIT-1:0]                w_next_row;
    logic [WIDTH_BIT-1:0]                w_next_col;
    logic [31:0]                         w_next_data;

    always_comb begin
        w_start     = done & ~r_done_q;
        w_hs        = r_valid & out_ready;
        w_final     = (r_row == LastIdx) && (r_col == LastIdx);
        w_next_col  = (r_col == LastIdx) ? '0 : r_col + 1'b1;
        w_next_row  = (r_col == LastIdx) ? r_row + 1'b1 : r_row;
        w_next_data = r_snap[w_next_row][w_next_col];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= StIdle;
            r_done_q  <= 1'b0;
            r_snap    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
            r_sum     <= '0;
            r_is_chk  <= 1'b0;
`endif
        end else begin
            r_done_q <= done;
            // A start that arrives while a frame is still owned (even on its last edge) is dropped.
            if (w_start && (r_state != StIdle)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_snap  <= result;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_data  <= result[0][0];
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= StStream;
`ifdef RESULT_CHECKSUM_EN
                        r_sum   <= '0;
`endif
                    end
                end
                StStream: begin
                    if (w_hs) begin
`ifdef RESULT_CHECKSUM_EN
                        r_sum <= r_sum + r_data;
`endif
                        if (!w_final) begin
                            r_row  <= w_next_row;
                            r_col  <= w_next_col;
                            r_data <= w_next_data;
`ifndef RESULT_CHECKSUM_EN
                            r_last <= (w_next_row == LastIdx) && (w_next_col == LastIdx);
`endif
                        end else begin
`ifdef RESULT_CHECKSUM_EN
                            r_row    <= '0;
                            r_col    <= '0;
                            r_data   <= r_sum + r_data;
                            r_last   <= 1'b1;
                            r_is_chk <= 1'b1;
                            r_state  <= StChk;
`else
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                            r_busy   <= 1'b0;
                            r_state  <= StIdle;
`endif
                        end
                    end
                end
`ifdef RESULT_CHECKSUM_EN
                StChk: begin
                    if (w_hs) begin
                        r_valid  <= 1'b0;
                        r_last   <= 1'b0;
                        r_is_chk <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= StIdle;
                    end
                end
`endif
                default: r_state <= StIdle;
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_row   = r_row;
    assign out_col   = r_col;
    assign out_last  = r_last;
    assign busy      = r_busy;
    assign overrun   = r_overrun;
`ifdef RESULT_CHECKSUM_EN
    assign out_is_chk = r_is_chk;
`else
    assign out_is_chk = 1'b0;
`endif

endmodule

// File: tb/tb_result_streamer.sv
// Bench for result_streamer (WIDTH=2): queue-based frame model checked every cycle, plus literals.
// Follows RESULT_CHECKSUM_EN the same way the design does.
module tb_result_streamer;

    localparam int unsigned WB = 1;
    localparam int unsigned W  = 2;
`ifdef RESULT_CHECKSUM_EN
    localparam int NB = W * W + 1;
`else
    localparam int NB = W * W;
`endif

    typedef struct packed {
        logic [31:0]   data;
        logic [WB-1:0] row;
        logic [WB-1:0] col;
        logic          last;
        logic          chk;
    } beat_t;

    logic                       CLK;
    logic                       RST;
    logic                       done;
    logic [0:W-1][0:W-1][31:0]  result;
    logic                       out_valid;
    logic                       out_ready;
    logic [31:0]                out_data;
    logic [WB-1:0]              out_row;
    logic [WB-1:0]              out_col;
    logic                       out_last;
    logic                       out_is_chk;
    logic                       busy;
    logic                       overrun;

    beat_t       exp_q[$];
    logic [31:0] got[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          valid_cycles = 0;
    bit          m_ovr = 0;
    bit          m_done_q = 0;

    result_streamer #(.WIDTH_BIT(WB), .WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .done(done), .result(result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .out_is_chk(out_is_chk), .busy(busy), .overrun(overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Expected frame straight from the matrix: row-major elements, then optional sum word.
    function automatic void push_frame();
        logic [31:0] s;
        beat_t       b;
        s = '0;
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) begin
                b.data = result[r][c];
                b.row  = WB'(r);
                b.col  = WB'(c);
                b.chk  = 1'b0;
`ifdef RESULT_CHECKSUM_EN
                b.last = 1'b0;
`else
                b.last = (r == W - 1) && (c == W - 1);
`endif
                s = s + result[r][c];
                exp_q.push_back(b);
            end
        end
`ifdef RESULT_CHECKSUM_EN
        b.data = s;
        b.row  = '0;
        b.col  = '0;
        b.last = 1'b1;
        b.chk  = 1'b1;
        exp_q.push_back(b);
`endif
    endfunction

    // Compare, then advance the model for the upcoming posedge (inputs are stable here).
    always @(negedge CLK) begin
        bit st;
        if (!RST) begin
            exp_q.delete();
            m_ovr    = 0;
            m_done_q = 0;
            check("rst_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_overrun", overrun, 0);
            check("rst_data", out_data, 0);
            check("rst_last", out_last, 0);
            check("rst_is_chk", out_is_chk, 0);
            check("rst_row", out_row, 0);
            check("rst_col", out_col, 0);
        end else begin
            check("valid", out_valid, exp_q.size() != 0);
            check("busy", busy, exp_q.size() != 0);
            check("overrun", overrun, m_ovr);
            if (exp_q.size() != 0) begin
                valid_cycles++;
                check("data", out_data, exp_q[0].data);
                check("row", out_row, exp_q[0].row);
                check("col", out_col, exp_q[0].col);
                check("last", out_last, exp_q[0].last);
                check("is_chk", out_is_chk, exp_q[0].chk);
            end
            if (out_valid && out_ready) got.push_back(out_data);
            st = done && !m_done_q;
            if (exp_q.size() != 0) begin
                if (st) m_ovr = 1;
                if (out_ready) void'(exp_q.pop_front());
            end else if (st) begin
                push_frame();
            end
            m_done_q = done;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic set_mat(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
        result[0][0] = a;
        result[0][1] = b;
        result[1][0] = c;
        result[1][1] = d;
    endtask

    task automatic wait_idle(input int budget, output int cnt);
        cnt = 0;
        while (busy && cnt < budget) begin
            tick();
            cnt++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        tick();
        RST = 1'b1;
        tick();
    endtask

    task automatic check_basic_frame(input string tag);
        check({tag, "_n"}, got.size(), NB);
        check({tag, "_b0"}, got[0], 32'd1);
        check({tag, "_b1"}, got[1], 32'd2);
        check({tag, "_b2"}, got[2], 32'd3);
        check({tag, "_b3"}, got[3], 32'd4);
`ifdef RESULT_CHECKSUM_EN
        check({tag, "_chk"}, got[4], 32'd10);
`endif
    endtask

    initial begin
        int cnt;
        RST       = 1'b0;
        done      = 1'b0;
        out_ready = 1'b0;
        result    = '0;
        #12;
        check("lit_rst_valid", out_valid, 0);
        check("lit_rst_busy", busy, 0);
        @(posedge CLK);
        #1 RST = 1'b1;
        repeat (10) tick();
        check("lit_idle_valid", out_valid, 0);

        // Basic stream at full throughput.
        set_mat(1, 2, 3, 4);
        out_ready = 1'b1;
        got.delete();
        pulse_done();
        check("lit_lat_valid", out_valid, 1);
        check("lit_lat_data", out_data, 1);
        check("lit_lat_rc", {out_row, out_col}, 0);
        wait_idle(20, cnt);
        check("lit_tput_cycles", cnt, NB);
        check_basic_frame("basic");

        // Backpressure: ready alternates 0/1, starting low on the first valid cycle.
        out_ready = 1'b0;
        got.delete();
        valid_cycles = 0;
        pulse_done();
        cnt = 0;
        while (busy && cnt < 40) begin
            tick();
            out_ready = ~out_ready;
            cnt++;
        end
        check("bp_timeout", busy, 0);
        check("lit_bp_cycles", valid_cycles, 2 * NB);
        check_basic_frame("bp");

        // Overrun mid-frame plus snapshot isolation.
        out_ready = 1'b0;
        got.delete();
        pulse_done();
        tick();
        tick();
        set_mat(9, 9, 9, 9);
        pulse_done();
        tick();
        check("lit_ovr_mid", overrun, 1);
        out_ready = 1'b1;
        wait_idle(20, cnt);
        check_basic_frame("iso");
        do_reset();
        check("lit_ovr_clear", overrun, 0);

        // Start rising on the final-handshake edge is dropped; the next one is accepted.
        set_mat(1, 2, 3, 4);
        pulse_done();
        repeat (NB - 1) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("lit_ovr_final", overrun, 1);
        check("lit_ovr_final_busy", busy, 0);
        tick();
        pulse_done();
        check("lit_restart_valid", out_valid, 1);
        wait_idle(20, cnt);
        do_reset();

        // Wrapping checksum.
        set_mat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        got.delete();
        pulse_done();
        wait_idle(20, cnt);
`ifdef RESULT_CHECKSUM_EN
        check("lit_ff_chk", got[4], 32'hFFFF_FFFC);
`else
        check("lit_ff_last", got[3], 32'hFFFF_FFFF);
`endif

        // Reset mid-frame after two beats, then a fresh frame.
        set_mat(1, 2, 3, 4);
        pulse_done();
        tick();
        tick();
        #2 RST = 1'b0;
        #1;
        check("lit_async_valid", out_valid, 0);
        check("lit_async_data", out_data, 0);
        check("lit_async_busy", busy, 0);
        @(posedge CLK);
        #1 RST = 1'b1;
        repeat (3) tick();
        set_mat(5, 6, 7, 8);
        got.delete();
        pulse_done();
        check("lit_fresh_data", out_data, 5);
        check("lit_fresh_rc", {out_row, out_col}, 0);
        wait_idle(20, cnt);
        check("lit_fresh_b0", got[0], 32'd5);
        check("lit_fresh_b3", got[3], 32'd8);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
